// File: rtl/load_store_ctrl.sv
// load_store_ctrl: byte/halfword/word load-store sequencer for a single-port data memory.
// Define LOAD_STORE_CTRL_RMW_EN to build read-modify-write sub-word stores; otherwise they are rejected.
module load_store_ctrl #(
  parameter logic [31:0] ADDR_BASE = 32'd1024,
  parameter logic [31:0] ADDR_SPAN = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] data_address,
  output logic [31:0] data_in,
  output logic        we,
  output logic        re,
  input  logic [31:0] data_out
);
  typedef enum logic [2:0] {IDLE, LD_RD, LD_CAP, ST_RD, ST_MERGE, ST_WR, RESP} state_t;
  state_t      state, nxt, st_first;
  logic [31:0] addr_q, din_q, resp_q, ld_val;
  logic [1:0]  size_q;
  logic        signed_q, err_q, accept, err, sub_st_err;
  logic [32:0] a33, lo33, hi33;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  // 33-bit bounds so BASE+SPAN at the top of the address space cannot wrap
  assign a33  = {1'b0, req_addr};
  assign lo33 = {1'b0, ADDR_BASE};
  assign hi33 = lo33 + {1'b0, ADDR_SPAN};
`ifdef LOAD_STORE_CTRL_RMW_EN
  logic [31:0] mask, merged;
  assign sub_st_err = 1'b0;
  assign st_first   = req_size == 2'b10 ? ST_WR : ST_RD;
  assign mask   = size_q == 2'b00 ? 32'h0000_00ff << {addr_q[1:0], 3'b0} : 32'h0000_ffff << {addr_q[1:0], 3'b0};
  assign merged = (data_out & ~mask) | ((din_q << {addr_q[1:0], 3'b0}) & mask);
`else
  assign sub_st_err = req_write && req_size != 2'b10;
  assign st_first   = ST_WR;
`endif
  assign accept = state == IDLE && req_valid;
  assign err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && |req_addr[1:0]) || a33 < lo33 || a33 >= hi33 || sub_st_err;
  assign lane_b = data_out[{addr_q[1:0], 3'b0} +: 8];
  assign lane_h = data_out[{addr_q[1], 4'b0} +: 16];
  assign ld_val = size_q == 2'b00 ? {{24{signed_q & lane_b[7]}}, lane_b} :
                  size_q == 2'b01 ? {{16{signed_q & lane_h[15]}}, lane_h} : data_out;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = !req_valid ? IDLE : err ? RESP : req_write ? st_first : LD_RD;
      LD_RD:    nxt = LD_CAP;
      LD_CAP:   nxt = RESP;
`ifdef LOAD_STORE_CTRL_RMW_EN
      ST_RD:    nxt = ST_MERGE;
      ST_MERGE: nxt = ST_WR;
`endif
      ST_WR:    nxt = RESP;
      RESP:     nxt = resp_ready ? IDLE : RESP;
      default:  nxt = IDLE;
    endcase
  end
  always_comb begin
    req_ready  = rst_n && state == IDLE;
    re         = state == LD_RD || state == ST_RD;
    we         = state == ST_WR;
    resp_valid = state == RESP;
  end
  assign resp_data    = resp_valid ? resp_q : '0;
  assign resp_err     = resp_valid & err_q;
  assign data_address = {addr_q[31:2], 2'b00};
  assign data_in      = din_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q   <= '0;
      din_q    <= '0;
      resp_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        din_q    <= req_wdata;
        resp_q   <= '0;
        size_q   <= req_size;
        signed_q <= req_signed;
        err_q    <= err;
      end
      if (state == LD_CAP) resp_q <= ld_val;
`ifdef LOAD_STORE_CTRL_RMW_EN
      if (state == ST_MERGE) din_q <= merged;
`endif
    end
endmodule

// File: tb/tb_load_store_ctrl.sv
// tb_load_store_ctrl: random and directed load/store traffic checked against a byte-array memory model.
module tb_load_store_ctrl;
`ifdef LOAD_STORE_CTRL_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        req_valid = 0, req_write = 0, req_signed = 0, resp_ready = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, data_out = 0;
  logic        req_ready, resp_valid, resp_err, we, re;
  logic [31:0] resp_data, data_address, data_in;
  int          n_tests = 0, n_fail = 0;
  int          we_cnt = 0, re_cnt = 0, both_cnt = 0, addr_bad = 0;
  logic [31:0] last_din = 0, cur_aligned = 0;
  logic [31:0] mem [0:255];
  logic [7:0]  ref_mem [0:1023];

  always #5 clk = ~clk;

  load_store_ctrl #(.ADDR_BASE(32'd1024), .ADDR_SPAN(32'd1024)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .data_address(data_address), .data_in(data_in), .we(we), .re(re),
    .data_out(data_out));

  // data memory: read word valid the cycle after re is sampled
  always @(posedge clk) begin
    if (re) data_out <= mem[data_address[9:2]];
    if (we) mem[data_address[9:2]] <= data_in;
  end

  always @(negedge clk) if (rst_n) begin
    if (we) begin we_cnt++; last_din = data_in; end
    if (re) re_cnt++;
    if (we && re) both_cnt++;
    if (!req_ready && data_address !== cur_aligned) addr_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic e;
    int n, lat, t, off;
    logic [31:0] exp_d, exp_w;
    n = 1 << sz;
    off = int'(a) - 1024;
    e = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
        a < 32'd1024 || a >= 32'd2048 || (!RMW && wr && sz != 2'd2);
    exp_d = 0;
    exp_w = 0;
    if (!e && !wr) begin
      for (int i = 0; i < n; i++) exp_d[8*i +: 8] = ref_mem[off + i];
      if (sg && n < 4 && exp_d[8*n-1]) exp_d |= ~((32'd1 << (8*n)) - 1);
    end
    if (!e && wr) begin
      for (int i = 0; i < n; i++) ref_mem[off + i] = wd[8*i +: 8];
      for (int i = 0; i < 4; i++) exp_w[8*i +: 8] = ref_mem[(off & ~3) + i];
    end
    cur_aligned = a & ~32'd3;
    @(negedge clk);
    req_valid = 1; req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    check("accept", {31'b0, req_ready}, 1);
    we_cnt = 0; re_cnt = 0; both_cnt = 0; addr_bad = 0;
    @(negedge clk);
    req_valid = 0; req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    check("latency", lat, e ? 1 : !wr ? 3 : sz == 2'd2 ? 2 : 4);
    check("resp_data", resp_data, exp_d);
    check("resp_err", {31'b0, resp_err}, {31'b0, e});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, resp_valid}, 1);
      check("hold_data", resp_data, exp_d);
      check("hold_ready", {31'b0, req_ready}, 0);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    check("back_idle", {30'b0, resp_valid, req_ready}, 32'b01);
    check("we_pulses", we_cnt, {31'b0, !e && wr});
    check("re_pulses", re_cnt, {31'b0, !e && (!wr || sz != 2'd2)});
    check("we_re_overlap", both_cnt, 0);
    check("addr_hold", addr_bad, 0);
    if (!e && wr) check("data_in", last_din, exp_w);
  endtask

  task automatic abort_at(input logic wr, input logic [31:0] a, input int cyc);
    int t;
    cur_aligned = a;
    @(negedge clk);
    req_valid = 1; req_write = wr; req_size = 2'd2; req_signed = 0; req_addr = a; req_wdata = $urandom;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    req_valid = 0;
    for (int c = 1; c < cyc; c++) @(negedge clk);
    check("pre_abort", {30'b0, we, re}, wr ? 32'b10 : cyc == 1 ? 32'b01 : 32'b00);
    #2 rst_n = 0;
    #1;
    check("abort_outs", {28'b0, we, re, resp_valid, req_ready}, 0);
    check("abort_addr", data_address, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("abort_idle", {30'b0, resp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    logic [31:0] w, a;
    logic [1:0] sz;
    int r;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    #1 rst_n = 0;
    #1;
    check("reset_outs", {27'b0, we, re, resp_valid, resp_err, req_ready}, 0);
    check("reset_addr", data_address, 0);
    check("reset_data", resp_data | data_in, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    xact(1, 2'd2, 0, 32'd1024, 32'hFFFF_FFFF, 0);
    xact(0, 2'd2, 0, 32'd1024, 0, 0);
    xact(1, 2'd2, 0, 32'd1024, 32'h1122_3344, 0);
    xact(1, 2'd0, 0, 32'd1025, 32'h0000_00A5, 0);
    xact(0, 2'd0, 1, 32'd1025, 0, 0);
    xact(0, 2'd0, 0, 32'd1025, 0, 0);
    xact(0, 2'd2, 0, 32'd1026, 0, 0);
    xact(1, 2'd2, 0, 32'd1020, 32'hDEAD_BEEF, 0);
    xact(0, 2'd2, 0, 32'd1024, 0, 3);
    xact(1, 2'd1, 0, 32'd1024, 32'hCAFE_8001, 1);
    xact(1, 2'd1, 0, 32'd1026, 32'h0000_F00D, 0);
    xact(0, 2'd1, 1, 32'd1026, 0, 0);
    xact(0, 2'd1, 1, 32'd1027, 0, 0);
    xact(0, 2'd0, 1, 32'd2047, 0, 0);
    xact(0, 2'd0, 0, 32'd2048, 0, 0);
    xact(0, 2'd0, 0, 32'd1023, 0, 0);
    xact(0, 2'd3, 0, 32'd1024, 0, 0);
    abort_at(0, 32'd1028, 2);
    abort_at(0, 32'd1036, 1);
    abort_at(1, 32'd1032, 1);
    xact(0, 2'd2, 0, 32'd1032, 0, 0);
    xact(0, 2'd2, 0, 32'd1028, 0, 1);
    for (int k = 0; k < 150; k++) begin
      sz = 2'($urandom_range(0, 4) == 4 ? 2 : $urandom_range(0, 3));
      r = $urandom_range(0, 9);
      a = r == 0 ? $urandom_range(990, 1023) : r == 1 ? $urandom_range(2040, 2060) :
          r == 2 ? $urandom : $urandom_range(1024, 2047);
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
      xact(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 2));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_ctrl.md
LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 Parameter ADDR_BASE, default 1024, lowest legal byte address of data memory.
REQ-002 Parameter ADDR_SPAN, default 1024, number of legal bytes starting at ADDR_BASE.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Req_valid  input  1  core presents a load/store request.
REQ-006 Req_ready  output  1  block accepts request this cycle.
REQ-007 Req_write  input  1  1 = store, 0 = load.
REQ-008 Req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 Req_signed  input  1  sign-extend sub-word load data.
REQ-010 Req_addr  input  32  byte address.
REQ-011 Req_wdata  input  32  store data, right-justified.
REQ-012 Resp_valid  output  1  response available.
REQ-013 Resp_ready  input  1  core consumes response.
REQ-014 Resp_data  output  32  load result, extended; 0 for stores and errors.
REQ-015 Resp_err  output  1  request rejected, no memory write performed.
REQ-016 Data_address  output  32  word-aligned byte address to data memory (Req_addr with bits [1:0] cleared).
REQ-017 Data_in  output  32  write word to data memory.
REQ-018 we  output  1  data memory write enable.
REQ-019 re  output  1  data memory read enable.
REQ-020 Data_out  input  32  data memory read word, valid the cycle after re is sampled high.

Function
REQ-021 States SHALL be IDLE, LD_RD, LD_CAP, ST_RD, ST_MERGE, ST_WR, RESP.
REQ-022 Req_ready SHALL be 1 only in IDLE; a request is accepted when Req_valid and Req_ready are both 1.
REQ-023 Errors SHALL be: Req_size 11; halfword with addr[0]=1; word with addr[1:0]!=0; addr<ADDR_BASE or addr>=ADDR_BASE+ADDR_SPAN.
REQ-024 On an errored request, IDLE->RESP with Resp_err=1, Resp_data=0, and we and re never asserted.
REQ-025 Load: IDLE->LD_RD (re=1)->LD_CAP (Data_out captured, lane selected, extended)->RESP; Resp_valid first high 3 cycles after accept.
REQ-026 Lane select SHALL be little-endian: byte lane addr[1:0], halfword lane addr[1].
REQ-027 Word store: IDLE->ST_WR (we=1, Data_in=Req_wdata)->RESP; Resp_valid first high 2 cycles after accept.
REQ-028 Sub-word store: IDLE->ST_RD (re=1)->ST_MERGE (replace addressed lane of Data_out with Req_wdata low bits)->ST_WR (we=1)->RESP.
REQ-029 we and re SHALL never be high in the same cycle; both 0 outside LD_RD, ST_RD, ST_WR.
REQ-030 Data_address SHALL hold the registered request address for every cycle of a transaction.
REQ-031 RESP SHALL hold Resp_valid, Resp_data, Resp_err stable until Resp_ready=1, then return to IDLE next cycle.
REQ-032 Req_* inputs SHALL be registered at acceptance; changes after acceptance have no effect.
REQ-033 Address range check SHALL use 33-bit arithmetic so ADDR_BASE+ADDR_SPAN cannot wrap.

Reset
REQ-034 Rst_n low SHALL immediately force state IDLE and all outputs to 0 except Req_ready, which goes to 1 only after Rst_n is high.
REQ-035 Reset mid-transaction SHALL abort it: we and re drop combinationally with Rst_n; no response is issued.

Configuration
REQ-036 Macro LOAD_STORE_CTRL_RMW_EN defined: sub-word stores SHALL follow REQ-028.
REQ-037 Macro LOAD_STORE_CTRL_RMW_EN undefined: sub-word stores SHALL be errors (REQ-024); ST_RD and ST_MERGE are not built; loads unaffected.

Verification
REQ-038 Word store 0xFFFFFFFF at 1024, then word load at 1024 -> one we pulse at address 1024, load Resp_data 0xFFFFFFFF, Resp_err 0, latencies 2 and 3 cycles.
REQ-039 Memory word 1024 = 0x11223344; byte store 0xA5 at 1025 (RMW_EN) -> re then we, Data_in 0x1122A544; signed byte load at 1025 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
REQ-040 Word load at 1026 and word store at 1020 -> Resp_err 1, Resp_data 0, we and re stay 0 throughout.
REQ-041 Load response with Resp_ready held 0 for 3 cycles -> Resp_valid, Resp_data constant, Req_ready 0 until handshake.
REQ-042 Rst_n pulsed low during LD_CAP -> we, re, Resp_valid 0 immediately; next request after reset completes normally.
REQ-043 Without LOAD_STORE_CTRL_RMW_EN, halfword store at 1024 -> Resp_err 1, no we pulse.
